// File: rtl/rand_burst_parm_pkg.sv
// Shared definitions for the burst-framed 802.16 OFDM randomizer (PRBS 1+x^14+x^15).
package rand_burst_parm_pkg;

  localparam int IV_W  = 15;
  localparam int TAP_A = 13;
  localparam int TAP_B = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic prbs_fb(input logic [IV_W-1:0] r);
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/rand_burst_parm_lfsr_step.sv
// Combinational W-step advance of the randomizer LFSR; bit 0 of the beat is stepped first.
module rand_burst_parm_lfsr_step
  import rand_burst_parm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [IV_W-1:0] r,
  input  logic [W-1:0]    in_bits,
  output logic [IV_W-1:0] r_next,
  output logic [W-1:0]    out_bits
);

  logic [IV_W-1:0] r_s;
  logic            fb_s;

  // Chain W single-bit steps: fb feeds both the data XOR and the shift input
  always_comb begin
    r_s      = r;
    fb_s     = 1'b0;
    out_bits = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      fb_s        = prbs_fb(r_s);
      out_bits[i] = in_bits[i] ^ fb_s;
      r_s         = {r_s[IV_W-2:0], fb_s};
    end
    r_next = r_s;
  end

endmodule

// File: rtl/rand_burst_parm.sv
// Burst-framed randomizer: per-burst IV/length/bypass, valid/ready on both sides,
// single registered output stage with out_last on the final beat.
module rand_burst_parm
  import rand_burst_parm_pkg::*;
#(
  parameter int W     = 1,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IV_W-1:0]  load_iv,
  input  logic [LEN_W-1:0] load_bits,
  input  logic             load_byp,
  output logic             load_err,
  output logic             busy,
  input  logic [W-1:0]     in_bits,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam logic [LEN_W-1:0] W_L    = LEN_W'(W);
  localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};

  state_e           state_r;
  logic [IV_W-1:0]  lfsr_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] len_r;
  logic             byp_r;
  logic [W-1:0]     out_bits_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             load_err_r;
  logic             busy_r;

  logic [IV_W-1:0]  step_r_s;
  logic [W-1:0]     step_out_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             load_ok_s;
  logic [LEN_W-1:0] cnt_next_s;
  logic             last_s;

  rand_burst_parm_lfsr_step #(.W(W)) u_step (
    .r        (lfsr_r),
    .in_bits  (in_bits),
    .r_next   (step_r_s),
    .out_bits (step_out_s)
  );

  // Input acceptance: only while running, and only if the output register is free this cycle
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_RUN:  in_ready_s = !out_valid_r || out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_fire_s  = in_valid && in_ready_s;
  assign out_fire_s = out_valid_r && out_ready;
  assign load_ok_s  = (load_bits != ZERO_L) && ((load_bits % W_L) == ZERO_L);
  assign cnt_next_s = cnt_r + W_L;
  assign last_s     = (cnt_next_s == len_r);

  // Burst FSM, bit counter, LFSR and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= {IV_W{1'b0}};
      cnt_r       <= ZERO_L;
      len_r       <= ZERO_L;
      byp_r       <= 1'b0;
      out_bits_r  <= {W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      load_err_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      load_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            if (load_ok_s) begin
              lfsr_r  <= load_iv;
              len_r   <= load_bits;
              byp_r   <= load_byp;
              cnt_r   <= ZERO_L;
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              load_err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          load_err_r <= load;
          if (in_fire_s) begin
            // Bypass still advances the LFSR so the keystream stays aligned to the bit count
            lfsr_r      <= step_r_s;
            cnt_r       <= cnt_next_s;
            out_bits_r  <= byp_r ? in_bits : step_out_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_s;
            if (last_s) begin
              state_r <= ST_DRAIN;
            end
          end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          load_err_r <= load;
          if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_bits  = out_bits_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign load_err  = load_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rand_burst_parm.sv
// Scoreboard bench for rand_burst_parm: random bursts checked against a sequence-recurrence PRBS model.
module tb_rand_burst_parm;

  localparam int W     = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [14:0]      load_iv;
  logic [LEN_W-1:0] load_bits;
  logic             load_byp;
  logic             load_err;
  logic             busy;
  logic [W-1:0]     in_bits;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_bits;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  always #5 clk = ~clk;

  rand_burst_parm #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_iv(load_iv), .load_bits(load_bits),
    .load_byp(load_byp), .load_err(load_err), .busy(busy), .in_bits(in_bits),
    .in_valid(in_valid), .in_ready(in_ready), .out_bits(out_bits), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct packed {
    logic [W-1:0] bits;
    logic         last;
  } beat_t;

  int           n_chk = 0;
  int           n_fail = 0;
  beat_t        sb_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] data_q[$];
  bit           ks_q[$];
  bit           mon_en = 1'b0;
  int           rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Keystream from the recurrence s[n] = s[n-14] ^ s[n-15]; IV bit i is the bit emitted i+1 steps ago.
  task automatic gen_ks(input logic [14:0] iv, input int nbits);
    bit s[$];
    ks_q.delete();
    for (int j = 0; j < 15; j++) s.push_back(iv[14-j]);
    for (int n = 0; n < nbits; n++) begin
      s.push_back(s[n+1] ^ s[n]);
      ks_q.push_back(s[n+15]);
    end
  endtask

  // Output monitor: pop-and-compare on every output handshake, hold check while stalled
  initial begin
    logic [W-1:0] hold_bits;
    logic         hold_last;
    bit           hold_v;
    beat_t        e;
    hold_v = 1'b0;
    hold_bits = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid) begin
        if (hold_v) begin
          chk("stall_bits", 32'(out_bits), 32'(hold_bits));
          chk("stall_last", 32'(out_last), 32'(hold_last));
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h with no beat pending", out_bits);
          end else begin
            e = sb_q.pop_front();
            chk("out_bits", 32'(out_bits), 32'(e.bits));
            chk("out_last", 32'(out_last), 32'(e.last));
            obs_q.push_back(out_bits);
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_bits = out_bits;
          hold_last = out_last;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Sink backpressure pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic do_load(input logic [14:0] iv, input logic [LEN_W-1:0] bits, input logic byp,
                         input bit exp_ok);
    load = 1'b1; load_iv = iv; load_bits = bits; load_byp = byp;
    @(posedge clk); #1;
    load = 1'b0;
    chk("load_err", 32'(load_err), exp_ok ? 32'd0 : 32'd1);
    chk("load_busy", 32'(busy), exp_ok ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk("load_err_pulse", 32'(load_err), 32'd0);
  endtask

  // Drive a burst from data_q; stop_at < nbeats abandons it after that many input beats
  task automatic run_burst(input logic [14:0] iv, input int nbeats, input logic byp,
                           input bit gaps, input int inj, input int stop_at);
    int i = 0, cyc = 0;
    bit fired_prev = 1'b0, load_prev = 1'b0, injected = 1'b0;
    logic [W-1:0] key;
    gen_ks(iv, nbeats * W);
    do_load(iv, LEN_W'(nbeats * W), byp, 1'b1);
    while (i < stop_at && cyc < 5000) begin
      if (fired_prev) chk("latency_valid", 32'(out_valid), 32'd1);
      if (load_prev) chk("run_load_err", 32'(load_err), 32'd1);
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bits = data_q[i];
      load = (i == inj) && !injected;
      if (load) begin
        load_iv = 15'($urandom); load_bits = LEN_W'(W); load_byp = ~byp;
      end
      @(negedge clk);
      fired_prev = in_valid && in_ready;
      load_prev = load;
      if (load) injected = 1'b1;
      if (fired_prev) begin
        for (int k = 0; k < W; k++) key[k] = ks_q[i*W+k];
        sb_q.push_back('{bits: data_q[i] ^ (byp ? {W{1'b0}} : key), last: (i == nbeats - 1)});
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    load = 1'b0;
    if (cyc >= 5000) begin
      n_chk++; n_fail++;
      $display("FAIL input_timeout: sent %0d beats, required %0d", i, stop_at);
    end
    if (fired_prev) chk("latency_valid", 32'(out_valid), 32'd1);
    if (load_prev) chk("run_load_err", 32'(load_err), 32'd1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((sb_q.size() != 0 || busy) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 500) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d beats pending, busy %0b", sb_q.size(), busy);
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic fill_data(input int n, input bit rnd, input logic [W-1:0] val);
    data_q.delete();
    for (int j = 0; j < n; j++) data_q.push_back(rnd ? W'($urandom) : val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  vec;
    logic [14:0]  iv;
    int           nb;
    reset = 1'b0; load = 1'b0; load_iv = '0; load_bits = '0; load_byp = 1'b0;
    in_bits = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_bits", 32'(out_bits), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // IV=1 on zero data: first 13 keystream bits 0, bit 13 is 1
    rdy_mode = 0;
    obs_q.delete();
    fill_data(8, 1'b0, '0);
    run_burst(15'h0001, 8, 1'b0, 1'b0, -1, 8);
    wait_drain();
    vec = '0;
    for (int b = 0; b < obs_q.size() && b < 8; b++)
      for (int k = 0; k < W; k++) vec[b*W+k] = obs_q[b][k];
    chk("prbs_first14", 32'(vec[13:0]), 32'h2000);

    // All-zero IV passes data unchanged
    fill_data(16, 1'b0, 4'hA);
    run_burst(15'h0000, 16, 1'b0, 1'b0, -1, 16);
    wait_drain();

    // Alternating backpressure
    rdy_mode = 1;
    fill_data(8, 1'b1, '0);
    run_burst(15'h5A3C, 8, 1'b0, 1'b0, -1, 8);
    wait_drain();

    // Rejected loads in IDLE, then a load during RUN
    rdy_mode = 0;
    do_load(15'h1234, 16'd10, 1'b0, 1'b0);
    do_load(15'h1234, 16'd0, 1'b0, 1'b0);
    fill_data(10, 1'b1, '0);
    run_burst(15'h7FFF, 10, 1'b0, 1'b0, 3, 10);
    wait_drain();

    // Bypass and single-beat bursts
    fill_data(6, 1'b1, '0);
    run_burst(15'h4321, 6, 1'b1, 1'b0, -1, 6);
    wait_drain();
    fill_data(1, 1'b1, '0);
    run_burst(15'h0ABC, 1, 1'b0, 1'b0, -1, 1);
    wait_drain();

    // Random bursts with random gaps, backpressure and mid-burst loads
    for (int t = 0; t < 20; t++) begin
      rdy_mode = $urandom_range(0, 2);
      nb = $urandom_range(1, 20);
      iv = 15'($urandom);
      fill_data(nb, 1'b1, '0);
      run_burst(iv, nb, ($urandom_range(0, 3) == 0), 1'b1,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb - 1) : -1, nb);
      wait_drain();
    end

    // Reset mid-burst, then restart with the same IV
    rdy_mode = 0;
    fill_data(10, 1'b1, '0);
    run_burst(15'h2468, 10, 1'b0, 1'b0, -1, 5);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_burst(15'h2468, 10, 1'b0, 1'b0, -1, 10);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
